// File: rtl/pc_fetch_unit_pkg.sv
// Shared types for the PC fetch stage: FSM state encoding and next-PC select codes.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_PLUS1  = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_JUMP   = 2'd3
  } sel_t;

endpackage

// File: rtl/pc_fetch_unit_next_mux.sv
// Combinational next-PC priority select: Halt > Stall > Jump > PCSrc > PC+1.
import pc_fetch_unit_pkg::*;

module pc_fetch_unit_next_mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_plus1,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             halt,
  input  logic             stall,
  input  logic             jump,
  input  logic             pc_src,
  output logic [WIDTH-1:0] next_pc,
  output sel_t             sel
);

  always_comb begin
    sel     = SEL_PLUS1;
    next_pc = pc_plus1;
    if (halt || stall) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end else if (jump) begin
      sel     = SEL_JUMP;
      next_pc = jump_target;
    end else if (pc_src) begin
      sel     = SEL_BRANCH;
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: PC register, boot/run/halt FSM and retire counter.
// Optional PC range check enabled by defining PC_BOUNDS_CHECK_EN.
//
// state  | meaning
// BOOT   | one cycle after reset, PC held at RESET_PC
// RUN    | instruction at PC valid, PC advances per next-PC select
// HALTED | halt decoded, PC held until Resume
// FAULT  | next PC out of imem range, terminal until reset
import pc_fetch_unit_pkg::*;

module pc_fetch_unit #(
  parameter int                    WIDTH      = 32,
  parameter logic [WIDTH-1:0]      RESET_PC   = '0,
  parameter int                    IMEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             PCSrc,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic [WIDTH-1:0] PCBranch,
  input  logic             Halt,
  input  logic             Resume,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus1,
  output logic             Running,
  output logic [WIDTH-1:0] RetireCount,
  output logic             Fault
);

  generate
    if (IMEM_DEPTH < 1) begin : g_bad_depth
      $error("IMEM_DEPTH must be at least 1");
    end
  endgenerate

  state_t           state, state_next;
  sel_t             sel;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] retire_q;
  logic             fault_hit;
  logic             pc_we;

  assign PC          = pc_q;
  assign PCPlus1     = pc_q + 1'b1;
  assign RetireCount = retire_q;

  pc_fetch_unit_next_mux #(.WIDTH(WIDTH)) u_next_mux (
    .pc            (pc_q),
    .pc_plus1      (PCPlus1),
    .branch_target (PCBranch),
    .jump_target   (JumpTarget),
    .halt          (Halt),
    .stall         (Stall),
    .jump          (Jump),
    .pc_src        (PCSrc),
    .next_pc       (next_pc),
    .sel           (sel)
  );

`ifdef PC_BOUNDS_CHECK_EN
  // Extra bit keeps the compare correct when IMEM_DEPTH equals 2^WIDTH.
  localparam logic [WIDTH:0] DEPTH_EXT = (WIDTH+1)'(IMEM_DEPTH);
  assign fault_hit = (state == RUN) && (sel != SEL_HOLD) &&
                     ({1'b0, next_pc} >= DEPTH_EXT);
`else
  assign fault_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN: begin
        if (Halt)           state_next = HALTED;
        else if (fault_hit) state_next = FAULT;
      end
      HALTED:  if (Resume) state_next = RUN;
      FAULT:   state_next = FAULT;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    Running = (state == RUN);
    pc_we   = (state == RUN) && (sel != SEL_HOLD) && !fault_hit;
`ifdef PC_BOUNDS_CHECK_EN
    Fault   = (state == FAULT);
`else
    Fault   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      retire_q <= '0;
    end else if (pc_we) begin
      pc_q     <= next_pc;
      retire_q <= retire_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: 32-bit instance for main flow, 8-bit instances for wrap and bounds.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 32-bit instance
  logic        a_reset, a_stall, a_pcsrc, a_jump, a_halt, a_resume;
  logic [31:0] a_jt, a_br;
  logic [31:0] a_pc, a_pcp1, a_rc;
  logic        a_run, a_fault;

  pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'd0), .IMEM_DEPTH(256)) dut_a (
    .clk(clk), .reset(a_reset), .Stall(a_stall), .PCSrc(a_pcsrc), .Jump(a_jump),
    .JumpTarget(a_jt), .PCBranch(a_br), .Halt(a_halt), .Resume(a_resume),
    .PC(a_pc), .PCPlus1(a_pcp1), .Running(a_run), .RetireCount(a_rc), .Fault(a_fault)
  );

  // 8-bit instances share stimulus, separate resets
  logic       b_reset, c_reset, b_stall, b_pcsrc, b_jump, b_halt, b_resume;
  logic [7:0] b_jt, b_br;
  logic [7:0] b_pc, b_pcp1, b_rc, c_pc, c_pcp1, c_rc;
  logic       b_run, b_fault, c_run, c_fault;

  pc_fetch_unit #(.WIDTH(8), .RESET_PC(8'h10), .IMEM_DEPTH(256)) dut_b (
    .clk(clk), .reset(b_reset), .Stall(b_stall), .PCSrc(b_pcsrc), .Jump(b_jump),
    .JumpTarget(b_jt), .PCBranch(b_br), .Halt(b_halt), .Resume(b_resume),
    .PC(b_pc), .PCPlus1(b_pcp1), .Running(b_run), .RetireCount(b_rc), .Fault(b_fault)
  );

  pc_fetch_unit #(.WIDTH(8), .RESET_PC(8'h00), .IMEM_DEPTH(16)) dut_c (
    .clk(clk), .reset(c_reset), .Stall(b_stall), .PCSrc(b_pcsrc), .Jump(b_jump),
    .JumpTarget(b_jt), .PCBranch(b_br), .Halt(b_halt), .Resume(b_resume),
    .PC(c_pc), .PCPlus1(c_pcp1), .Running(c_run), .RetireCount(c_rc), .Fault(c_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    a_reset = 1; a_stall = 0; a_pcsrc = 0; a_jump = 0; a_halt = 0; a_resume = 0;
    a_jt = '0; a_br = '0;
    b_reset = 1; c_reset = 1; b_stall = 0; b_pcsrc = 0; b_jump = 0; b_halt = 0;
    b_resume = 0; b_jt = '0; b_br = '0;

    // reset and boot
    step();
    a_reset = 0;
    chk("rst_pc", a_pc, 32'd0);
    chk("rst_running", 32'(a_run), 32'd0);
    chk("rst_retire", a_rc, 32'd0);
    chk("rst_pcplus1", a_pcp1, 32'd1);
    chk("rst_fault", 32'(a_fault), 32'd0);
    step();
    chk("boot_pc_hold", a_pc, 32'd0);
    chk("run_running", 32'(a_run), 32'd1);
    step();
    chk("idle_pc1", a_pc, 32'd1);
    step();
    chk("idle_pc2", a_pc, 32'd2);
    chk("idle_retire2", a_rc, 32'd2);
    step(3);
    chk("pc5", a_pc, 32'd5);

    // branch, then jump beats branch
    a_pcsrc = 1; a_br = 32'h20;
    step();
    chk("branch_pc", a_pc, 32'h20);
    a_jump = 1; a_jt = 32'h40; a_br = 32'h99;
    step();
    chk("jump_over_branch", a_pc, 32'h40);
    chk("retire7", a_rc, 32'd7);

    // stall hold
    a_pcsrc = 0; a_jt = 32'd7;
    step();
    a_jump = 0; a_stall = 1;
    step(3);
    chk("stall_pc", a_pc, 32'd7);
    chk("stall_retire", a_rc, 32'd8);
    chk("stall_running", 32'(a_run), 32'd1);
    a_stall = 0;
    step();
    chk("stall_release", a_pc, 32'd8);
    chk("stall_release_rc", a_rc, 32'd9);

    // halt and resume; Halt/Jump while halted must be ignored
    step();
    chk("pc9", a_pc, 32'd9);
    a_halt = 1;
    step();
    chk("halt_running", 32'(a_run), 32'd0);
    a_jump = 1; a_jt = 32'h55;
    step(5);
    chk("halted_pc", a_pc, 32'd9);
    chk("halted_running", 32'(a_run), 32'd0);
    chk("halted_retire", a_rc, 32'd10);
    a_jump = 0; a_resume = 1;
    step();
    chk("resume_running", 32'(a_run), 32'd1);
    chk("resume_pc", a_pc, 32'd9);
    a_resume = 0; a_halt = 0;
    step();
    chk("resume_next_pc", a_pc, 32'd10);

    // halt + stall + jump together: halt taken, PC holds
    a_halt = 1; a_stall = 1; a_jump = 1; a_jt = 32'h30;
    step();
    chk("halt_stall_pc", a_pc, 32'd10);
    chk("halt_stall_running", 32'(a_run), 32'd0);
    chk("halt_stall_rc", a_rc, 32'd11);
    a_halt = 0; a_stall = 0; a_jump = 0;
    a_reset = 1;
    step();
    a_reset = 0;
    chk("halt_reset_pc", a_pc, 32'd0);
    chk("halt_reset_running", 32'(a_run), 32'd0);
    chk("halt_reset_rc", a_rc, 32'd0);
    chk("default_fault", 32'(a_fault), 32'd0);

    // 8-bit wrap and reset during halt
    b_reset = 0;
    step();
    chk("b_boot_pc", 32'(b_pc), 32'h10);
    b_jump = 1; b_jt = 8'hFF;
    step();
    chk("b_pc_ff", 32'(b_pc), 32'hFF);
    chk("b_pcplus1_wrap", 32'(b_pcp1), 32'h00);
    b_jump = 0;
    step();
    chk("b_pc_wrap", 32'(b_pc), 32'h00);
    chk("b_retire", 32'(b_rc), 32'd2);
    b_halt = 1;
    step();
    chk("b_halted", 32'(b_run), 32'd0);
    b_halt = 0; b_reset = 1;
    step();
    b_reset = 0;
    chk("b_reset_pc", 32'(b_pc), 32'h10);
    chk("b_reset_running", 32'(b_run), 32'd0);
    chk("b_reset_rc", 32'(b_rc), 32'd0);

`ifdef PC_BOUNDS_CHECK_EN
    c_reset = 1;
    step();
    c_reset = 0;
    step();
    b_jump = 1; b_jt = 8'd15;
    step();
    chk("c_in_range", 32'(c_pc), 32'd15);
    chk("c_no_fault", 32'(c_fault), 32'd0);
    b_jt = 8'd16;
    step();
    chk("c_fault", 32'(c_fault), 32'd1);
    chk("c_fault_pc", 32'(c_pc), 32'd15);
    chk("c_fault_rc", 32'(c_rc), 32'd1);
    chk("c_fault_running", 32'(c_run), 32'd0);
    b_jt = 8'd3;
    step(2);
    chk("c_fault_sticky", 32'(c_fault), 32'd1);
    chk("c_fault_pc_hold", 32'(c_pc), 32'd15);
    b_jump = 0; c_reset = 1;
    step();
    c_reset = 0;
    chk("c_fault_clear", 32'(c_fault), 32'd0);
    chk("c_reset_pc", 32'(c_pc), 32'd0);
`else
    b_jump = 1; b_jt = 8'd16; c_reset = 0;
    step(3);
    chk("c_fault_disabled", 32'(c_fault), 32'd0);
    chk("c_pc_no_check", 32'(c_pc), 32'd16);
    b_jump = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
